exec_unit: RTL

Multi-cycle execute stage that sits directly downstream of the 9-entry × 15-bit two-read/one-write register file. It drives the file's read addresses, captures the two operands, performs one of eight ALU/multiply operations and writes the result back through the file's write port. It uses a START/BUSY/DONE handshake, so a sequencer issues one instruction at a time.

---
 rtl/exec_unit.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_unit.sv
// Multi-cycle execute stage: reads two operands from the register file, runs one
// of eight ALU/multiply operations and writes the result back through the write port.
module exec_unit #(
   parameter int DW    = 15,
   parameter int AW    = 4,
   parameter int NREGS = 9
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          START,
   input  logic [2:0]    OP,
   input  logic [AW-1:0] SRC1,
   input  logic [AW-1:0] SRC2,
   input  logic [AW-1:0] DST,
   input  logic [DW-1:0] RD1,
   input  logic [DW-1:0] RD2,
   output logic [AW-1:0] RA1,
   output logic [AW-1:0] RA2,
   output logic [AW-1:0] WA,
   output logic [DW-1:0] WRD,
   output logic          WE,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR,
   output logic          ZF,
   output logic          CF,
   output logic [1:0]    DBG_STATE
);

   // Handshake: START is taken only while BUSY is low. An accepted request ends
   // with DONE (coincident with WE); a rejected one with a single ERR pulse.
   // START seen while BUSY is dropped, never queued.

   localparam int SW = $clog2(DW);
   localparam int CW = $clog2(DW);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [AW-1:0]   dst_q, dst_d;
   logic [AW-1:0]   ra1_q, ra1_d;
   logic [AW-1:0]   ra2_q, ra2_d;
   logic [AW-1:0]   wa_q, wa_d;
   logic [DW-1:0]   wrd_q, wrd_d;
   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic [DW-1:0]   mplier_q, mplier_d;
   logic [2*DW-1:0] acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            zf_q, zf_d;
   logic            cf_q, cf_d;

   logic            req_ok;
   logic [DW:0]     add_w;
   logic [SW-1:0]   shamt;
   logic            sh_big;
   logic [DW-1:0]   alu_r;
   logic            alu_c;
   logic [2*DW-1:0] addend;
   logic [2*DW-1:0] acc_step;
   logic            mul_last;
   logic [DW-1:0]   res;
   logic            res_c;
   logic            finish;

   always_comb begin
      req_ok = (int'(SRC1) < NREGS) && (int'(SRC2) < NREGS) && (int'(DST) < NREGS);
   end

   // Single-cycle operations; only the low shift-amount bits matter.
   always_comb begin
      add_w  = {1'b0, a_q} + {1'b0, b_q};
      shamt  = b_q[SW-1:0];
      sh_big = (int'(shamt) >= DW);
      alu_r  = '0;
      alu_c  = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_r = add_w[DW-1:0];
            alu_c = add_w[DW];
         end
         OP_SUB: begin
            alu_r = a_q - b_q;
            alu_c = (a_q < b_q);
         end
         OP_AND: alu_r = a_q & b_q;
         OP_OR:  alu_r = a_q | b_q;
         OP_XOR: alu_r = a_q ^ b_q;
         OP_SHL: alu_r = sh_big ? '0 : (a_q << shamt);
         OP_SHR: alu_r = sh_big ? '0 : (a_q >> shamt);
         default: begin
            alu_r = '0;
            alu_c = 1'b0;
         end
      endcase
   end

   // Shift-add multiplier: cnt_q selects the multiplier bit weight this cycle.
   always_comb begin
      addend   = mplier_q[0] ? ({{DW{1'b0}}, a_q} << cnt_q) : '0;
      acc_step = acc_q + addend;
      mul_last = (cnt_q == CW'(DW - 1));
   end

   always_comb begin
      res    = alu_r;
      res_c  = alu_c;
      finish = 1'b1;
      if (op_q == OP_MUL) begin
         res    = acc_step[DW-1:0];
         res_c  = |acc_step[2*DW-1:DW];
         finish = mul_last;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      dst_d    = dst_q;
      ra1_d    = ra1_q;
      ra2_d    = ra2_q;
      wa_d     = wa_q;
      wrd_d    = wrd_q;
      a_d      = a_q;
      b_d      = b_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      we_d     = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      zf_d     = zf_q;
      cf_d     = cf_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               if (req_ok) begin
                  op_d    = OP;
                  dst_d   = DST;
                  ra1_d   = SRC1;
                  ra2_d   = SRC2;
                  state_d = ST_READ;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_READ: begin
            a_d      = RD1;
            b_d      = RD2;
            mplier_d = RD2;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_EXEC;
         end
         ST_EXEC: begin
            if (op_q == OP_MUL) begin
               acc_d    = acc_step;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CW'(1);
            end
            if (finish) begin
               wa_d    = dst_q;
               wrd_d   = res;
               we_d    = 1'b1;
               done_d  = 1'b1;
               zf_d    = (res == '0);
               cf_d    = res_c;
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         dst_q    <= '0;
         ra1_q    <= '0;
         ra2_q    <= '0;
         wa_q     <= '0;
         wrd_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         zf_q     <= 1'b0;
         cf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         dst_q    <= dst_d;
         ra1_q    <= ra1_d;
         ra2_q    <= ra2_d;
         wa_q     <= wa_d;
         wrd_q    <= wrd_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         done_q   <= done_d;
         err_q    <= err_d;
         zf_q     <= zf_d;
         cf_q     <= cf_d;
      end
   end

   assign RA1       = ra1_q;
   assign RA2       = ra2_q;
   assign WA        = wa_q;
   assign WRD       = wrd_q;
   assign WE        = we_q;
   assign DONE      = done_q;
   assign ERR       = err_q;
   assign ZF        = zf_q;
   assign CF        = cf_q;
   assign BUSY      = (state_q != ST_IDLE);
   assign DBG_STATE = state_q;

endmodule
